lmsm_sequencer: RTL and testbench
=================================

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the instruction and PC word width.
REQ-002 SHALL have parameter MASKW, default 8, the number of register-list bits in LM/SM (IR[7:0]).
REQ-003 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_ir, input, 16, instruction from the fetch pipe register.
REQ-006 SHALL have port in_pc, input, 16, PC of in_ir.
REQ-007 SHALL have port in_valid, input, 1, in_ir/in_pc hold a real instruction.
REQ-008 SHALL have port stall_in, input, 1, decode/downstream cannot accept a new word this cycle.
REQ-009 SHALL have port flush, input, 1, squash the current and in-flight instruction (branch/R7 redirect).
REQ-010 SHALL have port out_ir, output, 16, instruction or micro-op presented to decode.
REQ-011 SHALL have port out_pc, output, 16, PC presented to decode (the parent PC for every micro-op).
REQ-012 SHALL have port out_valid, output, 1, out_ir/out_pc are valid.
REQ-013 SHALL have port mem_offset, output, 16, zero-extended index of the current LM/SM micro-op (memory address = RA + mem_offset).
REQ-014 SHALL have port out_last, output, 1, out_ir is the final micro-op of its parent, or a non-LM/SM instruction.
REQ-015 SHALL have port stall_fetch, output, 1, fetch must hold in_ir/in_pc.

Function
REQ-016 SHALL register all outputs except stall_fetch, giving a 1-cycle latency from an accepted input to out_*.
REQ-017 SHALL accept an input only when in_valid=1, stall_in=0, flush=0, and state=IDLE.
REQ-018 SHALL pass a non-LM/SM opcode (IR[15:12] not 0110/0111) through unchanged, with mem_offset=0 and out_last=1.
REQ-019 SHALL, on an accepted LM/SM with IR[7:0]!=0, emit the micro-op {IR[15:9], 1'b0, onehot(lowest set bit of IR[7:0])}, with mem_offset=0.
REQ-020 SHALL store remaining = IR[7:0] with the emitted bit cleared, and enter SEQ if remaining!=0; otherwise it SHALL stay IDLE with out_last=1.
REQ-021 SHALL, in SEQ with stall_in=0, emit the next micro-op from the lowest set bit of remaining, clear that bit, and increment mem_offset by 1.
REQ-022 SHALL return to IDLE with out_last=1 on the emission that empties remaining.
REQ-023 SHALL drop an accepted LM/SM with IR[7:0]==0: out_valid=0 next cycle, no SEQ entry.
REQ-024 SHALL ignore IR[8] and force it to 0 in every micro-op.
REQ-025 SHALL hold all registered outputs, remaining, and state while stall_in=1.
REQ-026 SHALL drive stall_fetch = stall_in OR (state==SEQ), combinationally.
REQ-027 SHALL, when flush=1 at a clock edge, force state=IDLE, remaining=0, and out_valid=0, overriding stall_in and any acceptance.
REQ-028 SHALL, when in_valid=0 is sampled in IDLE with stall_in=0, deassert out_valid next cycle.
REQ-029 SHALL give an 8-register LM/SM exactly 8 micro-ops, with mem_offset 0..7; the 3-bit counter never wraps within one parent.

Reset
REQ-030 SHALL, while reset=1, asynchronously force state=IDLE, remaining=0, out_ir=0, out_pc=0, out_valid=0, mem_offset=0, and out_last=0.
REQ-031 SHALL drive stall_fetch = stall_in during reset, and discard any in-progress sequence.

Structure
REQ-032 SHALL take the opcode constants (LM=4'b0110, SM=4'b0111) and the state encodings (IDLE, SEQ) from the shared processor package, which decode also uses.
REQ-033 SHALL instantiate one sub-module, lsb_onehot8, an 8-bit lowest-set-bit one-hot selector that also outputs a "none" flag.

Verification
REQ-034 SHALL cover: ADD 16'h0A50 at PC 16'h0010 -> next cycle out_ir=16'h0A50, out_pc=16'h0010, out_valid=1, out_last=1, stall_fetch=0.
REQ-035 SHALL cover: LM 16'h6405 at PC 16'h0020 -> out_ir 16'h6401 (off 0) then 16'h6404 (off 1, last=1); stall_fetch=1 for exactly 1 cycle.
REQ-036 SHALL cover: SM 16'h7EFF -> 8 micro-ops 16'h7E01..16'h7E80 in order, offsets 0..7, stall_fetch=1 for 7 cycles, out_last only on the 8th.
REQ-037 SHALL cover: LM 16'h6200 (empty mask) -> out_valid=0 next cycle, state remains IDLE.
REQ-038 SHALL cover: SM 16'h70FF with stall_in=1 for 3 cycles after the 2nd micro-op -> 16'h7002 holds, then the sequence resumes at 16'h7004 with offset 2.
REQ-039 SHALL cover: flush, or an async reset pulse, during the 3rd micro-op of 16'h60FF -> out_valid=0, stall_fetch=0 (with stall_in=0), and the next input is accepted normally.

Source files
------------

// File: rtl/lmsm_pkg.sv
// Shared processor constants: LM/SM opcodes and the multi-register sequencer
// state encoding, also consumed by decode.
package lmsm_pkg;

   localparam logic [3:0] OPC_LM = 4'b0110;
   localparam logic [3:0] OPC_SM = 4'b0111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } seq_state_t;

   // True for the two multi-register memory opcodes.
   function automatic logic is_lmsm_op(input logic [3:0] opc);
      return (opc == OPC_LM) || (opc == OPC_SM);
   endfunction

endpackage

// File: rtl/lsb_onehot8.sv
// 8-bit lowest-set-bit selector: one-hot of the least significant 1, plus a
// flag for an all-zero input.
module lsb_onehot8 (
   input  logic [7:0] vec,
   output logic [7:0] onehot,
   output logic       none
);

   // Two's-complement trick isolates the lowest set bit; zero input gives zero.
   always_comb begin
      onehot = vec & (~vec + 8'd1);
      none   = (vec == 8'd0);
   end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer: passes ordinary instructions through and expands
// each load/store-multiple into one single-register micro-op per mask bit,
// lowest register first, holding fetch while the expansion runs.
module lmsm_sequencer
   import lmsm_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MASKW = 8   // the selector is 8 bits wide, so this stays 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_ir,
   input  logic [WIDTH-1:0] in_pc,
   input  logic             in_valid,
   input  logic             stall_in,
   input  logic             flush,
   output logic [WIDTH-1:0] out_ir,
   output logic [WIDTH-1:0] out_pc,
   output logic             out_valid,
   output logic [WIDTH-1:0] mem_offset,
   output logic             out_last,
   output logic             stall_fetch
);

   localparam int OFFW = $clog2(MASKW);

   seq_state_t       state_q, state_d;
   logic [MASKW-1:0] rem_q, rem_d;
   logic [OFFW-1:0]  off_q, off_d;
   logic [WIDTH-1:0] out_ir_d, out_pc_d;
   logic             out_valid_d, out_last_d;

   logic [MASKW-1:0] sel_vec, sel_onehot, rem_after;
   logic             sel_none;

   // Pick the mask being consumed: the new instruction in IDLE, the leftover bits in SEQ.
   always_comb begin
      sel_vec   = (state_q == ST_SEQ) ? rem_q : in_ir[MASKW-1:0];
      rem_after = sel_vec & ~sel_onehot;
   end

   lsb_onehot8 u_sel (
      .vec    (sel_vec),
      .onehot (sel_onehot),
      .none   (sel_none)
   );

   // Next-state and next-output decision; flush beats stall, stall freezes everything.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      off_d       = off_q;
      out_ir_d    = out_ir;
      out_pc_d    = out_pc;
      out_valid_d = out_valid;
      out_last_d  = out_last;
      if (flush) begin
         state_d     = ST_IDLE;
         rem_d       = '0;
         out_valid_d = 1'b0;
      end else if (!stall_in) begin
         case (state_q)
            ST_IDLE: begin
               if (!in_valid) begin
                  out_valid_d = 1'b0;
               end else if (!is_lmsm_op(in_ir[WIDTH-1:WIDTH-4])) begin
                  out_ir_d    = in_ir;
                  out_pc_d    = in_pc;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b1;
                  off_d       = '0;
               end else if (sel_none) begin
                  // Empty register list: nothing to transfer, instruction vanishes.
                  out_valid_d = 1'b0;
               end else begin
                  // IR[8] is not part of the micro-op encoding and is forced low.
                  out_ir_d    = {in_ir[WIDTH-1:MASKW+1], 1'b0, sel_onehot};
                  out_pc_d    = in_pc;
                  out_valid_d = 1'b1;
                  off_d       = '0;
                  rem_d       = rem_after;
                  out_last_d  = (rem_after == '0);
                  state_d     = (rem_after == '0) ? ST_IDLE : ST_SEQ;
               end
            end
            ST_SEQ: begin
               // Upper opcode/RA bits are still sitting in out_ir from the previous micro-op.
               out_ir_d    = {out_ir[WIDTH-1:MASKW+1], 1'b0, sel_onehot};
               out_valid_d = 1'b1;
               off_d       = off_q + OFFW'(1);
               rem_d       = rem_after;
               out_last_d  = (rem_after == '0);
               if (rem_after == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and registered outputs, cleared asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         off_q     <= '0;
         out_ir    <= '0;
         out_pc    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         off_q     <= off_d;
         out_ir    <= out_ir_d;
         out_pc    <= out_pc_d;
         out_valid <= out_valid_d;
         out_last  <= out_last_d;
      end
   end

   // Offset counter is narrow; present it zero-extended to the address width.
   always_comb begin
      mem_offset  = {{(WIDTH-OFFW){1'b0}}, off_q};
      stall_fetch = stall_in | (state_q == ST_SEQ);
   end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: inputs change on the falling edge and
// outputs are inspected on the falling edge after each rising edge.
module tb_lmsm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in_ir, in_pc;
   logic        in_valid, stall_in, flush;
   logic [15:0] out_ir, out_pc, mem_offset;
   logic        out_valid, out_last, stall_fetch;

   int n_cmp  = 0;
   int n_fail = 0;

   lmsm_sequencer #(.WIDTH(16), .MASKW(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_ir       (in_ir),
      .in_pc       (in_pc),
      .in_valid    (in_valid),
      .stall_in    (stall_in),
      .flush       (flush),
      .out_ir      (out_ir),
      .out_pc      (out_pc),
      .out_valid   (out_valid),
      .mem_offset  (mem_offset),
      .out_last    (out_last),
      .stall_fetch (stall_fetch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_ir = 16'h6405; in_pc = 16'h1234; in_valid = 1'b1;
      stall_in = 1'b1; flush = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_outs: got v=%b l=%b ir=%h pc=%h off=%h, want all zero",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      n_cmp++;
      if (stall_fetch !== 1'b1) begin
         n_fail++; $display("FAIL reset_stall_hi: got %b want 1", stall_fetch);
      end
      stall_in = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++;
      if (stall_fetch !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall_lo: got %b want 0", stall_fetch);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_passthrough();
      in_ir = 16'h0A50; in_pc = 16'h0010; in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b1, 16'h0A50, 16'h0010, 16'h0000}) begin
         n_fail++;
         $display("FAIL add_out: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=1 ir=0a50 pc=0010 off=0000",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      n_cmp++;
      if (stall_fetch !== 1'b0) begin
         n_fail++; $display("FAIL add_stall: got %b want 0", stall_fetch);
      end
      in_valid = 1'b0;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bubble_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_lm_two();
      int sf_cnt;
      sf_cnt = 0;
      in_ir = 16'h6405; in_pc = 16'h0020; in_valid = 1'b1;
      tick();
      if (stall_fetch) sf_cnt++;
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b0, 16'h6401, 16'h0020, 16'h0000}) begin
         n_fail++;
         $display("FAIL lm_op0: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=0 ir=6401 pc=0020 off=0000",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      tick();
      if (stall_fetch) sf_cnt++;
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b1, 16'h6404, 16'h0020, 16'h0001}) begin
         n_fail++;
         $display("FAIL lm_op1: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=1 ir=6404 pc=0020 off=0001",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      n_cmp++;
      if (sf_cnt != 1) begin
         n_fail++; $display("FAIL lm_stall_cycles: got %0d want 1", sf_cnt);
      end
      // Back-to-back: an ordinary instruction right after the expansion.
      in_ir = 16'h1234; in_pc = 16'h0021;
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b1, 16'h1234, 16'h0021, 16'h0000}) begin
         n_fail++;
         $display("FAIL b2b_add: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=1 ir=1234 pc=0021 off=0000",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_sm_full();
      int sf_cnt;
      logic [15:0] exp_ir;
      sf_cnt = 0;
      in_ir = 16'h7EFF; in_pc = 16'h0030; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (stall_fetch) sf_cnt++;
         exp_ir = 16'h7E00 | (16'h0001 << k);
         n_cmp++;
         if ({out_valid, out_last, out_ir, out_pc, mem_offset} !==
             {1'b1, (k == 7), exp_ir, 16'h0030, 16'(k)}) begin
            n_fail++;
            $display("FAIL sm_op%0d: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=%0d ir=%h pc=0030 off=%0d",
                     k, out_valid, out_last, out_ir, out_pc, mem_offset, (k == 7), exp_ir, k);
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (sf_cnt != 7) begin
         n_fail++; $display("FAIL sm_stall_cycles: got %0d want 7", sf_cnt);
      end
   endtask

   task automatic test_ir8_and_empty();
      in_ir = 16'h6301; in_pc = 16'h0090; in_valid = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b1, 16'h6201, 16'h0090, 16'h0000}) begin
         n_fail++;
         $display("FAIL ir8_op: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=1 ir=6201 pc=0090 off=0000",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      in_ir = 16'h6200; in_pc = 16'h0092;
      tick();
      n_cmp++;
      if ({out_valid, stall_fetch} !== 2'b00) begin
         n_fail++; $display("FAIL empty_mask: got v=%b sf=%b want v=0 sf=0", out_valid, stall_fetch);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_stall();
      logic [15:0] exp_ir;
      in_ir = 16'h70FF; in_pc = 16'h0040; in_valid = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, mem_offset} !== {1'b1, 1'b0, 16'h7002, 16'h0001}) begin
         n_fail++;
         $display("FAIL stall_pre: got v=%b l=%b ir=%h off=%h, want v=1 l=0 ir=7002 off=0001",
                  out_valid, out_last, out_ir, mem_offset);
      end
      stall_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if ({out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch} !==
             {1'b1, 1'b0, 16'h7002, 16'h0040, 16'h0001, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got v=%b l=%b ir=%h pc=%h off=%h sf=%b, want v=1 l=0 ir=7002 pc=0040 off=0001 sf=1",
                     c, out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch);
         end
      end
      stall_in = 1'b0;
      for (int k = 2; k < 8; k++) begin
         tick();
         exp_ir = 16'h7000 | (16'h0001 << k);
         n_cmp++;
         if ({out_valid, out_last, out_ir, mem_offset} !== {1'b1, (k == 7), exp_ir, 16'(k)}) begin
            n_fail++;
            $display("FAIL stall_resume%0d: got v=%b l=%b ir=%h off=%h, want v=1 l=%0d ir=%h off=%0d",
                     k, out_valid, out_last, out_ir, mem_offset, (k == 7), exp_ir, k);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      in_ir = 16'h60FF; in_pc = 16'h0060; in_valid = 1'b1;
      tick(); tick(); tick();
      n_cmp++;
      if ({out_valid, out_ir, mem_offset} !== {1'b1, 16'h6004, 16'h0002}) begin
         n_fail++;
         $display("FAIL flush_pre: got v=%b ir=%h off=%h, want v=1 ir=6004 off=0002", out_valid, out_ir, mem_offset);
      end
      flush = 1'b1;
      tick();
      n_cmp++;
      if ({out_valid, stall_fetch} !== 2'b00) begin
         n_fail++; $display("FAIL flush_squash: got v=%b sf=%b want v=0 sf=0", out_valid, stall_fetch);
      end
      flush = 1'b0; in_ir = 16'h0A50; in_pc = 16'h0050;
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset} !== {1'b1, 1'b1, 16'h0A50, 16'h0050, 16'h0000}) begin
         n_fail++;
         $display("FAIL flush_next: got v=%b l=%b ir=%h pc=%h off=%h, want v=1 l=1 ir=0a50 pc=0050 off=0000",
                  out_valid, out_last, out_ir, out_pc, mem_offset);
      end
      // Flush must win over a simultaneous stall.
      stall_in = 1'b1; flush = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_over_stall: got v=%b want 0", out_valid);
      end
      stall_in = 1'b0; flush = 1'b0; in_valid = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      in_ir = 16'h60FF; in_pc = 16'h0070; in_valid = 1'b1;
      tick(); tick(); tick();
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch} !== 51'd0) begin
         n_fail++;
         $display("FAIL areset_clear: got v=%b l=%b ir=%h pc=%h off=%h sf=%b, want all zero",
                  out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch);
      end
      reset = 1'b0;
      in_ir = 16'h6405; in_pc = 16'h0080;
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch} !==
          {1'b1, 1'b0, 16'h6401, 16'h0080, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL areset_next0: got v=%b l=%b ir=%h pc=%h off=%h sf=%b, want v=1 l=0 ir=6401 pc=0080 off=0000 sf=1",
                  out_valid, out_last, out_ir, out_pc, mem_offset, stall_fetch);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_last, out_ir, mem_offset, stall_fetch} !== {1'b1, 1'b1, 16'h6404, 16'h0001, 1'b0}) begin
         n_fail++;
         $display("FAIL areset_next1: got v=%b l=%b ir=%h off=%h sf=%b, want v=1 l=1 ir=6404 off=0001 sf=0",
                  out_valid, out_last, out_ir, mem_offset, stall_fetch);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lm_two();
      test_sm_full();
      test_ir8_and_empty();
      test_stall();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
